// File: rtl/rv_dmem_mmio.sv
// ---------------------------------------------------------------------------
// rv_dmem_mmio
//
// Sits between the core's data port and data memory. Addresses inside the
// 16-byte window at MMIO_BASE are handled locally and never reach memory:
//
//   offset 0  TX_DATA  store pushes wr_data[7:0] (needs byte_en[0]); reads 0
//   offset 1  STATUS   bit0 FULL, bit1 EMPTY, bit2 OVF, bits[8:4] count;
//                      a store with wr_data[2]=1 clears the sticky OVF bit
//   offset 2  CYC_LO   cycle counter [31:0]; the read also snapshots [63:32]
//   offset 3  CYC_HI   the [63:32] snapshot taken by the last CYC_LO read
//
// Optional feature: the 64-bit cycle counter and its HI snapshot exist only
// when the macro RV_MMIO_CYCLE_CNT_EN is defined; otherwise offsets 2 and 3
// read as 0 and no counter flops are built.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   addr/wr_data/wr_en/rd_en/byte_en_Q103H   core data request (stage Q103H)
//   mem_wr_en_Q103H     store enable forwarded to data memory (non-MMIO only)
//   mem_rd_data_Q104H   data memory read data (stage Q104H)
//   rd_data_Q104H       load data returned to the core (stage Q104H)
//   tx_valid/tx_data    TX FIFO head towards the byte consumer
//   tx_ready            consumer accepts the head byte
// ---------------------------------------------------------------------------
module rv_dmem_mmio #(
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_Q103H,
    input  logic [31:0] wr_data_Q103H,
    input  logic        wr_en_Q103H,
    input  logic        rd_en_Q103H,
    input  logic [3:0]  byte_en_Q103H,
    output logic        mem_wr_en_Q103H,
    input  logic [31:0] mem_rd_data_Q104H,
    output logic [31:0] rd_data_Q104H,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // ---------------- address decode ----------------
    logic       is_mmio;
    logic [1:0] offset;
    logic       mmio_wr;
    logic       mmio_rd;

    assign is_mmio         = (addr_Q103H[31:4] == MMIO_BASE[31:4]);
    assign offset          = addr_Q103H[3:2];
    assign mmio_wr         = wr_en_Q103H & is_mmio;
    assign mmio_rd         = rd_en_Q103H & is_mmio;
    assign mem_wr_en_Q103H = wr_en_Q103H & ~is_mmio;

    // Inputs that the register map never looks at.
    logic unused_bits;
    assign unused_bits = ^{byte_en_Q103H[3:1], wr_data_Q103H[31:8], addr_Q103H[1:0]};

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          accept;
    logic          ovf_set;
    logic          ovf_clr;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = ~empty;
    assign tx_data  = fifo_mem[rd_ptr];

    assign push    = mmio_wr & (offset == 2'd0) & byte_en_Q103H[0];
    assign pop     = tx_valid & tx_ready;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign accept  = push & (~full | pop);
    assign ovf_set = push & full & ~pop;
    assign ovf_clr = mmio_wr & (offset == 2'd1) & wr_data_Q103H[2];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Set wins over a same-cycle clear so an overflow is never lost.
            ovf <= ovf_set | (ovf & ~ovf_clr);
        end
    end

    // NOTE: the storage array has no reset; count/pointers decide which
    // entries are meaningful, so stale bytes are never observable.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= wr_data_Q103H[7:0];
    end

    logic [31:0] status;
    assign status = {23'd0, 5'(count), 1'b0, ovf, empty, full};

    // ---------------- optional cycle counter ----------------
`ifdef RV_MMIO_CYCLE_CNT_EN
    logic [63:0] cycle_cnt;
    logic [31:0] hi_snap;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            hi_snap   <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            // Snapshot HI with LO so a LO-then-HI read pair is coherent.
            if (mmio_rd && offset == 2'd2) hi_snap <= cycle_cnt[63:32];
        end
    end
`endif

    // ---------------- read mux (pre-store values) ----------------
    logic [31:0] mmio_rd_value;

    // NOTE: every always_comb output gets a default first so no latch is
    // inferred for unlisted offsets.
    always_comb begin
        mmio_rd_value = '0;
        case (offset)
            2'd1:    mmio_rd_value = status;
`ifdef RV_MMIO_CYCLE_CNT_EN
            2'd2:    mmio_rd_value = cycle_cnt[31:0];
            2'd3:    mmio_rd_value = hi_snap;
`endif
            default: mmio_rd_value = '0;
        endcase
    end

    // ---------------- Q104H load return ----------------
    logic        mmio_flag_Q104H;
    logic [31:0] mmio_val_Q104H;

    always_ff @(posedge clk) begin
        if (rst) begin
            mmio_flag_Q104H <= 1'b0;
            mmio_val_Q104H  <= '0;
        end else begin
            mmio_flag_Q104H <= mmio_rd;
            mmio_val_Q104H  <= mmio_rd_value;
        end
    end

    assign rd_data_Q104H = mmio_flag_Q104H ? mmio_val_Q104H : mem_rd_data_Q104H;

endmodule

// File: tb/tb_rv_dmem_mmio.sv
// ---------------------------------------------------------------------------
// tb_rv_dmem_mmio
//
// Directed bench for rv_dmem_mmio (default parameters, FIFO_DEPTH = 4).
// A table of single-cycle vectors covers decode, TX push/drain, STATUS and
// OVF handling; hand-written sequences cover push-while-full-with-pop,
// store+load in one cycle, mid-operation reset and (when the cycle counter
// is compiled in) the LO/HI snapshot across the 32-bit wrap.
// ---------------------------------------------------------------------------
module tb_rv_dmem_mmio;

    localparam logic [31:0] B   = 32'hFFFF_0000;   // TX_DATA
    localparam logic [31:0] S   = 32'hFFFF_0004;   // STATUS
    localparam logic [31:0] CLO = 32'hFFFF_0008;   // CYC_LO
    localparam logic [31:0] CHI = 32'hFFFF_000C;   // CYC_HI

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_Q103H;
    logic [31:0] wr_data_Q103H;
    logic        wr_en_Q103H;
    logic        rd_en_Q103H;
    logic [3:0]  byte_en_Q103H;
    logic        mem_wr_en_Q103H;
    logic [31:0] mem_rd_data_Q104H;
    logic [31:0] rd_data_Q104H;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int tests_run = 0;
    int tests_failed = 0;
    logic mwe_seen;

    always #5 clk = ~clk;

    rv_dmem_mmio dut (
        .clk               (clk),
        .rst               (rst),
        .addr_Q103H        (addr_Q103H),
        .wr_data_Q103H     (wr_data_Q103H),
        .wr_en_Q103H       (wr_en_Q103H),
        .rd_en_Q103H       (rd_en_Q103H),
        .byte_en_Q103H     (byte_en_Q103H),
        .mem_wr_en_Q103H   (mem_wr_en_Q103H),
        .mem_rd_data_Q104H (mem_rd_data_Q104H),
        .rd_data_Q104H     (rd_data_Q104H),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic        rd;
        logic [3:0]  be;
        logic        rdy;
        logic [31:0] mrd;
        logic        exp_mwe;
        logic [31:0] exp_rd;
        logic        exp_tv;
        logic [7:0]  exp_td;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(input logic [31:0] a, wd, input logic w, r,
                                input logic [3:0] be, input logic rdy,
                                input logic [31:0] mrd, input logic mwe,
                                input logic [31:0] erd, input logic tv,
                                input logic [7:0] td);
        vec_t v;
        v.addr = a;  v.wdata = wd; v.wr = w; v.rd = r; v.be = be; v.rdy = rdy;
        v.mrd = mrd; v.exp_mwe = mwe; v.exp_rd = erd; v.exp_tv = tv; v.exp_td = td;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One request cycle: drive after the falling edge, capture the
    // combinational store enable, then return just after the rising edge.
    task automatic cycle(input logic [31:0] a, wd, input logic w, r,
                         input logic [3:0] be, input logic rdy, input logic [31:0] mrd);
        @(negedge clk);
        addr_Q103H = a; wr_data_Q103H = wd; wr_en_Q103H = w; rd_en_Q103H = r;
        byte_en_Q103H = be; tx_ready = rdy; mem_rd_data_Q104H = mrd;
        #1 mwe_seen = mem_wr_en_Q103H;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, rdy, 32'h0);
    endtask

    task automatic push(input logic [7:0] d, input logic rdy);
        cycle(B, {24'h0, d}, 1'b1, 1'b0, 4'h1, rdy, 32'h0);
    endtask

    task automatic read(input logic [31:0] a);
        cycle(a, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [7:0] drain_exp [4];
        drain_exp[0] = 8'h22; drain_exp[1] = 8'h33; drain_exp[2] = 8'h44; drain_exp[3] = 8'hAA;

        //          addr         wdata  wr rd be    rdy mrd            mwe exp_rd       tv td
        vecs[0]  = mk(32'h0,     32'h0,  0, 0, 4'h0, 0, 32'h1234_5678, 0, 32'h1234_5678, 0, 8'h00);
        vecs[1]  = mk(B,         32'h41, 1, 0, 4'h1, 0, 32'h0,         0, 32'h0,         1, 8'h41);
        vecs[2]  = mk(S,         32'h0,  0, 1, 4'h0, 0, 32'h0,         0, 32'h010,       1, 8'h41);
        vecs[3]  = mk(32'h0,     32'h0,  0, 0, 4'h0, 1, 32'h0,         0, 32'h0,         0, 8'h00);
        vecs[4]  = mk(B,         32'h01, 1, 0, 4'h1, 0, 32'h0,         0, 32'h0,         1, 8'h01);
        vecs[5]  = mk(B,         32'h02, 1, 0, 4'h1, 0, 32'h0,         0, 32'h0,         1, 8'h01);
        vecs[6]  = mk(B,         32'h03, 1, 0, 4'h1, 0, 32'h0,         0, 32'h0,         1, 8'h01);
        vecs[7]  = mk(B,         32'h04, 1, 0, 4'h1, 0, 32'h0,         0, 32'h0,         1, 8'h01);
        vecs[8]  = mk(B,         32'h05, 1, 0, 4'h1, 0, 32'h0,         0, 32'h0,         1, 8'h01);
        vecs[9]  = mk(S,         32'h0,  0, 1, 4'h0, 0, 32'h0,         0, 32'h045,       1, 8'h01);
        vecs[10] = mk(32'h0,     32'h0,  0, 0, 4'h0, 1, 32'h0,         0, 32'h0,         1, 8'h02);
        vecs[11] = mk(32'h0,     32'h0,  0, 0, 4'h0, 1, 32'h0,         0, 32'h0,         1, 8'h03);
        vecs[12] = mk(32'h0,     32'h0,  0, 0, 4'h0, 1, 32'h0,         0, 32'h0,         1, 8'h04);
        vecs[13] = mk(32'h0,     32'h0,  0, 0, 4'h0, 1, 32'h0,         0, 32'h0,         0, 8'h00);
        vecs[14] = mk(S,         32'h0,  0, 1, 4'h0, 0, 32'h0,         0, 32'h006,       0, 8'h00);
        vecs[15] = mk(S,         32'h4,  1, 0, 4'hF, 0, 32'h0,         0, 32'h0,         0, 8'h00);
        vecs[16] = mk(S,         32'h0,  0, 1, 4'h0, 0, 32'h0,         0, 32'h002,       0, 8'h00);
        vecs[17] = mk(B,         32'h77, 1, 0, 4'hE, 0, 32'h0,         0, 32'h0,         0, 8'h00);
        vecs[18] = mk(B,         32'h0,  0, 1, 4'h0, 0, 32'hCAFE_F00D, 0, 32'h0,         0, 8'h00);
        vecs[19] = mk(32'h1000,  32'h0,  0, 1, 4'h0, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 8'h00);
        vecs[20] = mk(32'h1000,  32'h99, 1, 0, 4'hF, 0, 32'h0,         1, 32'h0,         0, 8'h00);
        vecs[21] = mk(32'hFFFE_FFFC, 32'h1, 1, 0, 4'h1, 0, 32'h0,      1, 32'h0,         0, 8'h00);
        vecs[22] = mk(32'hFFFF_0010, 32'h1, 1, 0, 4'h1, 0, 32'h0,      1, 32'h0,         0, 8'h00);
        vecs[23] = mk(S,         32'h0,  0, 1, 4'h0, 0, 32'h0,         0, 32'h002,       0, 8'h00);

        // ---- reset state ----
        rst = 1'b1;
        addr_Q103H = '0; wr_data_Q103H = '0; wr_en_Q103H = 1'b0; rd_en_Q103H = 1'b0;
        byte_en_Q103H = '0; tx_ready = 1'b0; mem_rd_data_Q104H = '0;
        cycle(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h5A5A_5A5A);
        cycle(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h5A5A_5A5A);
        check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("reset_rd_data", rd_data_Q104H, 32'h5A5A_5A5A);
        rst = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < 24; i++) begin
            cycle(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].rd,
                  vecs[i].be, vecs[i].rdy, vecs[i].mrd);
            check($sformatf("vec%0d_mem_wr_en", i), {31'h0, mwe_seen}, {31'h0, vecs[i].exp_mwe});
            check($sformatf("vec%0d_rd_data", i), rd_data_Q104H, vecs[i].exp_rd);
            check($sformatf("vec%0d_tx_valid", i), {31'h0, tx_valid}, {31'h0, vecs[i].exp_tv});
            if (vecs[i].exp_tv)
                check($sformatf("vec%0d_tx_data", i), {24'h0, tx_data}, {24'h0, vecs[i].exp_td});
        end

        // ---- full FIFO: push with simultaneous pop, then overflow ----
        push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b0);
        push(8'hAA, 1'b1);
        check("fullpop_head", {24'h0, tx_data}, 32'h22);
        read(S);
        check("fullpop_status", rd_data_Q104H, 32'h041);
        push(8'hBB, 1'b0);
        // Store (clear OVF) and load of STATUS together: load sees pre-store value.
        cycle(S, 32'h4, 1'b1, 1'b1, 4'hF, 1'b0, 32'h0);
        check("st_ld_same_cycle", rd_data_Q104H, 32'h045);
        read(S);
        check("ovf_cleared", rd_data_Q104H, 32'h041);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d_valid", i), {31'h0, tx_valid}, 32'h1);
            check($sformatf("drain%0d_data", i), {24'h0, tx_data}, {24'h0, drain_exp[i]});
            idle(1'b1);
        end
        check("drain_empty", {31'h0, tx_valid}, 32'h0);

        // ---- reset mid-operation with bytes queued ----
        push(8'h05, 1'b0); push(8'h06, 1'b0); push(8'h07, 1'b0);
        check("queued_valid", {31'h0, tx_valid}, 32'h1);
        rst = 1'b1;
        cycle(B, 32'h08, 1'b1, 1'b0, 4'h1, 1'b1, 32'h0BAD_F00D);
        rst = 1'b0;
        check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("midrst_rd_data", rd_data_Q104H, 32'h0BAD_F00D);
        read(S);
        check("midrst_status", rd_data_Q104H, 32'h002);
        read(CLO);
`ifdef RV_MMIO_CYCLE_CNT_EN
        check("midrst_cyc_small", {31'h0, (rd_data_Q104H < 32'd16)}, 32'h1);

        // ---- counter wrap across the 32-bit boundary ----
        @(negedge clk);
        force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFE;
        @(posedge clk);
        #1 release dut.cycle_cnt;
        idle(1'b0);
        idle(1'b0);
        read(CLO);
        check("cyc_lo_wrap", rd_data_Q104H, 32'h0);
        idle(1'b0);
        read(CHI);
        check("cyc_hi_snap", rd_data_Q104H, 32'h1);
`else
        check("midrst_cyc_lo", rd_data_Q104H, 32'h0);
        read(CHI);
        check("cyc_hi_absent", rd_data_Q104H, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
